// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and element-to-bit-offset mapping
// used by the feeder's packing and the systolic controller's unpacking.
package systolic_pkg;
    localparam logic ST_FILL  = 1'b0;
    localparam logic ST_ISSUE = 1'b1;

    function automatic int elem_off(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/systolic_feeder_pack.sv
// systolic_feeder_pack: beat counter and write-decode that packs the serial
// element stream into the flattened A and B buses.
module systolic_feeder_pack
    import systolic_pkg::*;
#(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int WIDTH = 4,
    parameter int N_A   = ROWS * ROWS,
    parameter int N_B   = ROWS * COLS,
    parameter int CW    = $clog2(N_A + N_B + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   beat,
    input  logic [WIDTH-1:0]       data,
    input  logic                   clear,
    output logic [CW-1:0]          cnt,
    output logic [N_A*WIDTH-1:0]   a,
    output logic [N_B*WIDTH-1:0]   b
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            a   <= '0;
            b   <= '0;
        end else begin
            cnt <= clear ? '0 : beat ? cnt + CW'(1) : cnt;
            for (int k = 0; k < N_A; k++)
                if (beat && cnt == CW'(k)) a[elem_off(k, WIDTH) +: WIDTH] <= data;
            for (int k = 0; k < N_B; k++)
                if (beat && cnt == CW'(N_A + k)) b[elem_off(k, WIDTH) +: WIDTH] <= data;
        end
    end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: frames a serial A/B element stream into flattened buses
// and issues them to the systolic array over a valid/ready handshake.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [ROWS*ROWS*WIDTH-1:0]  a,
    output logic [ROWS*COLS*WIDTH-1:0]  b,
    output logic                        in_valid,
    input  logic                        in_ready,
    output logic                        frame_err,
    output logic [15:0]                 frames_sent
);
    localparam int N_A   = ROWS * ROWS;
    localparam int N_TOT = ROWS * ROWS + ROWS * COLS;
    localparam int CW    = $clog2(N_TOT + 1);

    logic          state, next_state;
    logic [CW-1:0] cnt;
    logic          beat, last_idx, wr, clear;

    assign beat     = s_valid && s_ready;
    assign last_idx = cnt == CW'(N_TOT - 1);
    // A final-position beat without s_last is dropped rather than written.
    assign wr       = beat && !(last_idx && !s_last);
    assign clear    = beat && (s_last || last_idx);

    systolic_feeder_pack #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) u_pack (
        .clk   (clk),
        .rst_n (rst_n),
        .beat  (wr),
        .data  (s_data),
        .clear (clear),
        .cnt   (cnt),
        .a     (a),
        .b     (b)
    );

    always_comb
        next_state = (state == ST_FILL) ? ((beat && last_idx && s_last) ? ST_ISSUE : ST_FILL)
                                        : (in_ready ? ST_FILL : ST_ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FILL;
            in_valid    <= 1'b0;
            s_ready     <= 1'b0;
            frame_err   <= 1'b0;
            frames_sent <= '0;
        end else begin
            state       <= next_state;
            in_valid    <= next_state == ST_ISSUE;
            s_ready     <= next_state == ST_FILL;
            frame_err   <= beat && (s_last ^ last_idx);
            frames_sent <= frames_sent + 16'(in_valid && in_ready);
        end
    end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Initiator for the systolic block's matrix input handshake.
- Accepts a serial element stream: A elements row-major, then B elements row-major, one WIDTH-bit element per beat, framed by s_last.
- Packs the stream into the flattened a/b buses, then presents them with in_valid until in_ready completes the transfer.
- Sits between a host/DMA stream and the systolic top.

Parameters:
- ROWS, 2, array rows; A is ROWS x ROWS, B is ROWS x COLS.
- COLS, 2, array columns.
- WIDTH, 4, element width in bits.
- N_A (localparam), ROWS*ROWS, A element count.
- N_TOT (localparam), ROWS*ROWS + ROWS*COLS, elements per frame.
- CW (localparam), $clog2(N_TOT+1), beat counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  WIDTH  stream element.
- s_valid  in  1  stream element valid.
- s_last  in  1  marks final element of a frame.
- s_ready  out  1  feeder accepts an element this cycle.
- a  out  ROWS*ROWS*WIDTH  flattened A; element k at [k*WIDTH +: WIDTH].
- b  out  ROWS*COLS*WIDTH  flattened B; element k at [k*WIDTH +: WIDTH].
- in_valid  out  1  a/b hold a complete frame.
- in_ready  in  1  systolic accepts a/b.
- frame_err  out  1  one-cycle pulse: malformed frame discarded.
- frames_sent  out  16  count of completed in_valid/in_ready transfers; wraps at 2^16.

Behaviour:
- Reset: one clock domain, asynchronous active-low reset on rst_n. While rst_n is low: state=FILL, cnt=0, a=0, b=0, in_valid=0, s_ready=0, frame_err=0, frames_sent=0.
- s_ready is a registered output. It rises on the first clk edge after rst_n deasserts; thereafter s_ready_q <= (next_state==FILL).
- Beat: s_valid && s_ready at a rising edge.
- States: FILL and ISSUE.
- FILL, on each beat:
  - cnt<N_A writes A element cnt; otherwise writes B element cnt-N_A.
  - cnt increments.
  - The beat with cnt==N_TOT-1 and s_last=1 moves to ISSUE, sets in_valid=1, s_ready=0, cnt=0.
- FILL, framing errors:
  - s_last=1 on a beat with cnt<N_TOT-1: frame_err pulses next cycle, cnt=0, stay in FILL. Partial a/b contents are left as-is and are not issued.
  - cnt==N_TOT-1 beat with s_last=0: frame_err pulses, cnt=0, stay in FILL. Element is dropped, no issue.
  - frame_err is set only in these two cases and cleared otherwise.
- ISSUE:
  - in_valid=1; a/b stable; s_ready=0, so no beats are accepted.
  - in_valid && in_ready at an edge: state=FILL, in_valid=0, s_ready=1, frames_sent+1.
  - in_ready while in_valid=0 is ignored.
  - in_valid never drops without a handshake.
- Throughput:
  - Last-beat edge to in_valid high: 1 cycle.
  - Handshake to next beat accepted: 1 cycle.
  - Frame period is N_TOT+1 cycles minimum with in_ready held high.
- a/b retain their last values after the handshake until overwritten by the next frame.
- Reset mid-frame or mid-ISSUE returns to the reset values immediately; the partial frame is lost.
- s_data/s_last are ignored when s_valid=0.

Decomposition:
- Shared package systolic_pkg holds:
  - state encoding localparams (ST_FILL=1'b0, ST_ISSUE=1'b1);
  - the element-index-to-bit-offset function, shared with the systolic controller's unpacking.
- One natural sub-module: systolic_feeder_pack. It is the counter plus write-decode for a/b, with inputs beat/data/clear and outputs cnt/a/b. The FSM and handshake stay in the top.

Test Plan (ROWS=COLS=2, WIDTH=4, N_TOT=8):
- Reset release, then stream 1..8 with s_last on the 8th, in_ready=1 → a=16'h4321, b=16'h8765. in_valid high for exactly 1 cycle; frames_sent=1; s_ready high again on the next cycle.
- Same frame with in_ready=0 for 5 cycles then 1 → in_valid held 6 cycles; a/b stable throughout; s_ready=0 throughout; frames_sent increments once.
- s_last on 5th element → frame_err single pulse, no in_valid. A following good frame A..F,0,1 (s_last on 8th) issues correctly.
- 8 elements, no s_last on 8th → frame_err pulse, no in_valid, cnt back to 0.
- s_valid toggling 1/0 every cycle → only valid beats counted; in_valid exactly 1 cycle after the 8th valid beat.
- rst_n low after 3 beats of a frame → all outputs 0 asynchronously. After release, a full fresh frame issues correctly with frames_sent=1.
